// File: rtl/microwave_pkg.sv
// Shared encodings and limits for the microwave control stage.
package microwave_pkg;

  // FSM state encoding; also presented on the display port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Entry holds at most min, sec-tens and sec-ones.
  localparam int MAX_DIGITS = 3;

  // Largest digit that may later be shifted into the seconds-tens position.
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1 while run is high and emits a
// registered one-cycle tick on wrap. The count holds while run is low so a
// paused cook resumes mid-second.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic zero_cnt,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Count while running, wrap at LAST with a tick; zero_cnt wins over run.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (zero_cnt) begin
        count <= '0;
      end else if (run) begin
        if (count == LAST) begin
          count <= '0;
          tick  <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave control stage: keypad digit entry into the BCD timer, start /
// stop-clear / door arbitration, magnetron enable and the once-per-second
// timer decrement enable.
//
// Handshake: key_valid is a one-cycle pulse with no back-pressure; the digit
// is either accepted in the cycle it is sampled (one-cycle timer_loadn strobe
// the next cycle) or silently dropped.
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_en,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  state_t     st;
  logic [3:0] d2, d1, d0;
  logic [1:0] digit_cnt;
  logic       key_ok;
  logic       start_ok;
  logic       run;

  assign state = st;

  // Qualifiers shared by the FSM and the prescaler controls.
  always_comb begin
    key_ok   = (st == ST_IDLE || st == ST_SET) && key_valid &&
               (key_digit <= 4'd9) && (digit_cnt < 2'(MAX_DIGITS)) &&
               (d0 <= SEC_TENS_MAX);
    // In SET the timer mirrors the shadow, so an all-zero shadow agrees with
    // timer_zero; both must show a non-empty entry before cooking.
    start_ok = (st == ST_SET) && start && !stop_clear && door_closed &&
               !timer_zero && ({d2, d1, d0} != 12'd0);
    // A door opening, stop or zero in COOK freezes the prescaler that cycle,
    // so timer_en can never follow a zero reading.
    run      = (st == ST_COOK) && door_closed && !stop_clear && !timer_zero;
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .zero_cnt (start_ok),
    .tick     (timer_en)
  );

  // Control FSM with registered outputs and the shadow digit register.
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= ST_IDLE;
      timer_clrn  <= 1'b0;
      timer_loadn <= 1'b1;
      timer_data  <= 4'd0;
      mag_on      <= 1'b0;
      done        <= 1'b0;
      d2          <= 4'd0;
      d1          <= 4'd0;
      d0          <= 4'd0;
      digit_cnt   <= 2'd0;
    end else begin
      timer_loadn <= 1'b1;
      timer_clrn  <= 1'b1;
      case (st)
        ST_IDLE, ST_SET: begin
          if (st == ST_SET && stop_clear) begin
            st         <= ST_IDLE;
            timer_clrn <= 1'b0;
            d2         <= 4'd0;
            d1         <= 4'd0;
            d0         <= 4'd0;
            digit_cnt  <= 2'd0;
          end else if (start_ok) begin
            st     <= ST_COOK;
            mag_on <= 1'b1;
          end else if (key_ok) begin
            st          <= ST_SET;
            d2          <= d1;
            d1          <= d0;
            d0          <= key_digit;
            digit_cnt   <= digit_cnt + 2'd1;
            timer_data  <= key_digit;
            timer_loadn <= 1'b0;
          end
        end
        ST_COOK: begin
          if (!door_closed || stop_clear) begin
            st     <= ST_PAUSE;
            mag_on <= 1'b0;
          end else if (timer_zero) begin
            st     <= ST_DONE;
            mag_on <= 1'b0;
            done   <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (stop_clear) begin
            st         <= ST_IDLE;
            timer_clrn <= 1'b0;
            d2         <= 4'd0;
            d1         <= 4'd0;
            d0         <= 4'd0;
            digit_cnt  <= 2'd0;
          end else if (start && door_closed) begin
            st     <= ST_COOK;
            mag_on <= 1'b1;
          end
        end
        ST_DONE: begin
          if (stop_clear || !door_closed) begin
            st         <= ST_IDLE;
            done       <= 1'b0;
            timer_clrn <= 1'b0;
            d2         <= 4'd0;
            d1         <= 4'd0;
            d0         <= 4'd0;
            digit_cnt  <= 2'd0;
          end
        end
        default: begin
          st     <= ST_IDLE;
          mag_on <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl with a behavioural BCD countdown timer model
// attached to the timer_* outputs.
module tb_microwave_ctrl;
  import microwave_pkg::*;

  localparam int TICK_DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_closed = 1'b1;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn;
  logic       timer_clrn;
  logic       timer_en;
  logic       mag_on;
  logic       done;
  logic [2:0] state;

  int         err_cnt = 0;
  int         chk_cnt = 0;
  int         strb_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  // Timer model digits: minutes, seconds-tens, seconds-ones.
  logic [3:0] t2 = 4'd0, t1 = 4'd0, t0 = 4'd0;

  // Clock / reset block
  always #5 clock = ~clock;

  microwave_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clock       (clock),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop_clear  (stop_clear),
    .door_closed (door_closed),
    .timer_zero  (timer_zero),
    .timer_data  (timer_data),
    .timer_loadn (timer_loadn),
    .timer_clrn  (timer_clrn),
    .timer_en    (timer_en),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state)
  );

  // Downstream BCD timer model: clear, shift-load, decrement.
  always @(posedge clock) begin
    if (timer_clrn === 1'b0) begin
      t2 <= 4'd0; t1 <= 4'd0; t0 <= 4'd0;
    end else if (timer_loadn === 1'b0) begin
      t2 <= t1; t1 <= t0; t0 <= timer_data;
    end else if (timer_en === 1'b1 && !timer_zero) begin
      if (t0 != 4'd0) t0 <= t0 - 4'd1;
      else begin
        t0 <= 4'd9;
        if (t1 != 4'd0) t1 <= t1 - 4'd1;
        else begin t1 <= 4'd5; t2 <= t2 - 4'd1; end
      end
    end
  end
  assign timer_zero = (t2 == 4'd0) && (t1 == 4'd0) && (t0 == 4'd0);

  // Scoreboard: every load strobe must match the next expected digit.
  always @(negedge clock) begin
    if (!reset && timer_loadn === 1'b0) begin
      strb_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL strobe_unexpected: got strobe with data=%0d, required no strobe", timer_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (timer_data !== mon_exp) begin
          err_cnt++;
          $display("FAIL strobe_data: got %0d, required %0d", timer_data, mon_exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d, input bit accept);
    key_valid = 1'b1;
    key_digit = d;
    if (accept) exp_q.push_back(d);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_clear = 1'b1;
    tick();
    stop_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk_cnt++;
      if (timer_clrn !== 1'b0) begin err_cnt++; $display("FAIL reset_clrn: got %b, required 0", timer_clrn); end
      chk_cnt++;
      if ({state, timer_loadn, timer_en, mag_on, done, timer_data} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
        err_cnt++;
        $display("FAIL reset_outputs: got st=%0d ld=%b en=%b mag=%b done=%b data=%0d, required 0,1,0,0,0,0",
                 state, timer_loadn, timer_en, mag_on, done, timer_data);
      end
    end
    reset = 1'b0;
    tick();
    chk_cnt++;
    if (timer_clrn !== 1'b1) begin err_cnt++; $display("FAIL reset_release_clrn: got %b, required 1", timer_clrn); end
    chk_cnt++;
    if (state !== ST_IDLE) begin err_cnt++; $display("FAIL reset_release_state: got %0d, required 0", state); end
  endtask

  task automatic test_keys();
    int s0;
    s0 = strb_cnt;
    press_key(4'd1, 1'b1);
    press_key(4'd3, 1'b1);
    press_key(4'd0, 1'b1);
    press_key(4'd5, 1'b0);
    tick();
    tick();
    chk_cnt++;
    if (strb_cnt - s0 != 3) begin err_cnt++; $display("FAIL keys_strobes: got %0d, required 3", strb_cnt - s0); end
    chk_cnt++;
    if ({t2, t1, t0} !== {4'd1, 4'd3, 4'd0}) begin err_cnt++; $display("FAIL keys_value: got %0d:%0d%0d, required 1:30", t2, t1, t0); end
    chk_cnt++;
    if (timer_data !== 4'd0) begin err_cnt++; $display("FAIL keys_data_hold: got %0d, required 0", timer_data); end
    chk_cnt++;
    if (state !== ST_SET) begin err_cnt++; $display("FAIL keys_state: got %0d, required 1", state); end
    pulse_stop();
    chk_cnt++;
    if ({state, timer_clrn} !== {3'd0, 1'b0}) begin err_cnt++; $display("FAIL keys_clear: got st=%0d clrn=%b, required 0,0", state, timer_clrn); end
    tick();
    chk_cnt++;
    if (timer_clrn !== 1'b1) begin err_cnt++; $display("FAIL keys_clrn_width: got %b, required 1", timer_clrn); end
  endtask

  task automatic test_reject();
    int s0;
    s0 = strb_cnt;
    press_key(4'd1, 1'b1);
    press_key(4'd7, 1'b1);
    press_key(4'd2, 1'b0);
    tick();
    tick();
    chk_cnt++;
    if (strb_cnt - s0 != 2) begin err_cnt++; $display("FAIL reject_strobes: got %0d, required 2", strb_cnt - s0); end
    chk_cnt++;
    if ({t2, t1, t0} !== {4'd0, 4'd1, 4'd7}) begin err_cnt++; $display("FAIL reject_value: got %0d:%0d%0d, required 0:17", t2, t1, t0); end
    pulse_stop();
    tick();
    // Non-BCD key in IDLE is dropped and does not leave IDLE.
    s0 = strb_cnt;
    press_key(4'hA, 1'b0);
    tick();
    chk_cnt++;
    if (state !== ST_IDLE || strb_cnt != s0) begin err_cnt++; $display("FAIL reject_nonbcd: got st=%0d strobes=%0d, required 0,0", state, strb_cnt - s0); end
    // d0 = 5 is the largest digit still allowed to shift into seconds-tens.
    press_key(4'd1, 1'b1);
    press_key(4'd5, 1'b1);
    press_key(4'd2, 1'b1);
    tick();
    chk_cnt++;
    if ({t2, t1, t0} !== {4'd1, 4'd5, 4'd2}) begin err_cnt++; $display("FAIL reject_boundary: got %0d:%0d%0d, required 1:52", t2, t1, t0); end
    pulse_stop();
    tick();
  endtask

  task automatic test_cook();
    int en_at[$];
    int done_at;
    logic mag_at_done;
    done_at = -1;
    mag_at_done = 1'bx;
    door_closed = 1'b1;
    press_key(4'd0, 1'b1);
    press_key(4'd2, 1'b1);
    tick();
    pulse_start();
    chk_cnt++;
    if ({state, mag_on} !== {3'd2, 1'b1}) begin err_cnt++; $display("FAIL cook_entry: got st=%0d mag=%b, required 2,1", state, mag_on); end
    for (int i = 0; i < 16; i++) begin
      if (timer_en === 1'b1) en_at.push_back(i);
      if (done === 1'b1 && done_at < 0) begin done_at = i; mag_at_done = mag_on; end
      tick();
    end
    chk_cnt++;
    if (en_at.size() != 2) begin err_cnt++; $display("FAIL cook_en_count: got %0d, required 2", en_at.size()); end
    chk_cnt++;
    if (en_at.size() > 0 && en_at[0] != 4) begin err_cnt++; $display("FAIL cook_en_first: got cycle %0d, required 4", en_at[0]); end
    chk_cnt++;
    if (en_at.size() > 1 && en_at[1] != 8) begin err_cnt++; $display("FAIL cook_en_second: got cycle %0d, required 8", en_at[1]); end
    chk_cnt++;
    if (done_at != 10) begin err_cnt++; $display("FAIL cook_done_cycle: got %0d, required 10", done_at); end
    chk_cnt++;
    if (mag_at_done !== 1'b0) begin err_cnt++; $display("FAIL cook_mag_at_done: got %b, required 0", mag_at_done); end
    chk_cnt++;
    if ({state, done, mag_on} !== {3'd4, 1'b1, 1'b0}) begin err_cnt++; $display("FAIL cook_done_hold: got st=%0d done=%b mag=%b, required 4,1,0", state, done, mag_on); end
    door_closed = 1'b0;
    tick();
    chk_cnt++;
    if ({state, done, timer_clrn} !== {3'd0, 1'b0, 1'b0}) begin err_cnt++; $display("FAIL cook_door_exit: got st=%0d done=%b clrn=%b, required 0,0,0", state, done, timer_clrn); end
    door_closed = 1'b1;
    tick();
  endtask

  task automatic test_pause();
    int en_n;
    int first_en;
    en_n = 0;
    first_en = -1;
    press_key(4'd0, 1'b1);
    press_key(4'd5, 1'b1);
    tick();
    pulse_start();
    tick();
    tick();
    door_closed = 1'b0;
    tick();
    chk_cnt++;
    if ({state, mag_on} !== {3'd3, 1'b0}) begin err_cnt++; $display("FAIL pause_door: got st=%0d mag=%b, required 3,0", state, mag_on); end
    repeat (3) begin
      if (timer_en === 1'b1) en_n++;
      tick();
    end
    door_closed = 1'b1;
    tick();
    chk_cnt++;
    if (en_n != 0 || state !== ST_PAUSE) begin err_cnt++; $display("FAIL pause_hold: got en=%0d st=%0d, required 0,3", en_n, state); end
    pulse_start();
    chk_cnt++;
    if ({state, mag_on} !== {3'd2, 1'b1}) begin err_cnt++; $display("FAIL pause_resume: got st=%0d mag=%b, required 2,1", state, mag_on); end
    for (int i = 0; i < 6; i++) begin
      if (timer_en === 1'b1 && first_en < 0) first_en = i;
      tick();
    end
    chk_cnt++;
    if (first_en != 2) begin err_cnt++; $display("FAIL pause_resume_en: got cycle %0d, required 2", first_en); end
    chk_cnt++;
    if ({t2, t1, t0} !== {4'd0, 4'd0, 4'd4}) begin err_cnt++; $display("FAIL pause_timer: got %0d:%0d%0d, required 0:04", t2, t1, t0); end
    pulse_stop();
    chk_cnt++;
    if ({state, mag_on} !== {3'd3, 1'b0}) begin err_cnt++; $display("FAIL pause_stop: got st=%0d mag=%b, required 3,0", state, mag_on); end
    pulse_stop();
    chk_cnt++;
    if ({state, timer_clrn} !== {3'd0, 1'b0}) begin err_cnt++; $display("FAIL pause_clear: got st=%0d clrn=%b, required 0,0", state, timer_clrn); end
    tick();
  endtask

  task automatic test_priority();
    press_key(4'd3, 1'b1);
    tick();
    start = 1'b1;
    stop_clear = 1'b1;
    tick();
    start = 1'b0;
    stop_clear = 1'b0;
    chk_cnt++;
    if ({state, timer_clrn, mag_on} !== {3'd0, 1'b0, 1'b0}) begin err_cnt++; $display("FAIL prio_stop_start: got st=%0d clrn=%b mag=%b, required 0,0,0", state, timer_clrn, mag_on); end
    tick();
    chk_cnt++;
    if ({mag_on, timer_clrn} !== {1'b0, 1'b1}) begin err_cnt++; $display("FAIL prio_after: got mag=%b clrn=%b, required 0,1", mag_on, timer_clrn); end
    press_key(4'd3, 1'b1);
    tick();
    door_closed = 1'b0;
    pulse_start();
    chk_cnt++;
    if ({state, mag_on} !== {3'd1, 1'b0}) begin err_cnt++; $display("FAIL prio_door_open: got st=%0d mag=%b, required 1,0", state, mag_on); end
    door_closed = 1'b1;
    pulse_stop();
    tick();
    press_key(4'd0, 1'b1);
    tick();
    pulse_start();
    chk_cnt++;
    if ({state, mag_on} !== {3'd1, 1'b0}) begin err_cnt++; $display("FAIL prio_zero_start: got st=%0d mag=%b, required 1,0", state, mag_on); end
    pulse_stop();
    tick();
  endtask

  task automatic test_reset_midop();
    press_key(4'd9, 1'b1);
    tick();
    pulse_start();
    chk_cnt++;
    if (mag_on !== 1'b1) begin err_cnt++; $display("FAIL midop_cook: got mag=%b, required 1", mag_on); end
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_cnt++;
    if ({state, mag_on, timer_clrn, timer_en} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin err_cnt++; $display("FAIL midop_reset: got st=%0d mag=%b clrn=%b en=%b, required 0,0,0,0", state, mag_on, timer_clrn, timer_en); end
    reset = 1'b0;
    tick();
    chk_cnt++;
    if ({state, timer_clrn} !== {3'd0, 1'b1}) begin err_cnt++; $display("FAIL midop_release: got st=%0d clrn=%b, required 0,1", state, timer_clrn); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_keys();
    test_reject();
    test_cook();
    test_pause();
    test_priority();
    test_reset_midop();
    tick();
    chk_cnt++;
    if (exp_q.size() != 0) begin err_cnt++; $display("FAIL scoreboard_drain: got %0d pending strobes, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
